// File: rtl/fp_wb_scheduler_if.sv
// Issue and writeback handshake bundle between the FP pipeline and the write-port scheduler.
// The master modport is the pipeline side; the slave modport is the scheduler.
interface fp_wb_scheduler_if #(
    parameter int DATA_W = 32
);
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [2:0]        issue_rs_use_i;
    logic [4:0]        issue_frs1_i;
    logic [4:0]        issue_frs2_i;
    logic [4:0]        issue_frs3_i;
    logic              issue_wr_i;
    logic [4:0]        issue_frd_i;
    logic              fpu_wb_valid_i;
    logic              lsu_wb_valid_i;
    logic              mov_wb_valid_i;
    logic [4:0]        fpu_wb_frd_i;
    logic [4:0]        lsu_wb_frd_i;
    logic [4:0]        mov_wb_frd_i;
    logic [DATA_W-1:0] fpu_wb_data_i;
    logic [DATA_W-1:0] lsu_wb_data_i;
    logic [DATA_W-1:0] mov_wb_data_i;
    logic              fpu_wb_ready_o;
    logic              lsu_wb_ready_o;
    logic              mov_wb_ready_o;
    logic              fregwrite_o;
    logic [4:0]        frd_o;
    logic [DATA_W-1:0] writeback_data_o;
    logic [5:0]        pending_cnt_o;
    logic              busy_o;
    logic              wb_err_o;

    modport slave (
        input  issue_valid_i, issue_rs_use_i, issue_frs1_i, issue_frs2_i, issue_frs3_i,
               issue_wr_i, issue_frd_i,
               fpu_wb_valid_i, lsu_wb_valid_i, mov_wb_valid_i,
               fpu_wb_frd_i, lsu_wb_frd_i, mov_wb_frd_i,
               fpu_wb_data_i, lsu_wb_data_i, mov_wb_data_i,
        output issue_ready_o, fpu_wb_ready_o, lsu_wb_ready_o, mov_wb_ready_o,
               fregwrite_o, frd_o, writeback_data_o, pending_cnt_o, busy_o, wb_err_o
    );

    modport master (
        output issue_valid_i, issue_rs_use_i, issue_frs1_i, issue_frs2_i, issue_frs3_i,
               issue_wr_i, issue_frd_i,
               fpu_wb_valid_i, lsu_wb_valid_i, mov_wb_valid_i,
               fpu_wb_frd_i, lsu_wb_frd_i, mov_wb_frd_i,
               fpu_wb_data_i, lsu_wb_data_i, mov_wb_data_i,
        input  issue_ready_o, fpu_wb_ready_o, lsu_wb_ready_o, mov_wb_ready_o,
               fregwrite_o, frd_o, writeback_data_o, pending_cnt_o, busy_o, wb_err_o
    );
endinterface

// File: rtl/fp_wb_scheduler.sv
// FP register-file write-port scheduler: pending-write scoreboard with RAW/WAW issue
// stall, and LSU/FPU/MOV writeback arbitration onto the single registered write port.
module fp_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    fp_wb_scheduler_if.slave bus
);
    localparam logic [1:0] PTR_LSU = 2'd0;
    localparam logic [1:0] PTR_FPU = 2'd1;
    localparam logic [1:0] PTR_MOV = 2'd2;

    logic [31:0]       r_pending;
    logic [5:0]        r_cnt;
    logic              r_fregwrite;
    logic [4:0]        r_frd;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_ptr;
    logic              r_wb_err;

    logic              w_issue_ready;
    logic              w_fire;
    logic [2:0]        w_req;
    logic [2:0]        w_rot;
    logic [2:0]        w_pick;
    logic [2:0]        w_gnt;
    logic              w_any;
    logic [4:0]        w_sel_frd;
    logic [DATA_W-1:0] w_sel_data;
    logic [1:0]        w_ptr_nxt;
    logic [31:0]       w_set;
    logic [31:0]       w_clr;
    logic [31:0]       w_pending_nxt;
    logic              w_err_hit;

    function automatic logic [2:0] first_one(input logic [2:0] req);
        if (req[0]) begin
            first_one = 3'b001;
        end else if (req[1]) begin
            first_one = 3'b010;
        end else if (req[2]) begin
            first_one = 3'b100;
        end else begin
            first_one = 3'b000;
        end
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        popcount32 = 6'd0;
        for (int i = 0; i < 32; i++) begin
            popcount32 = popcount32 + {5'd0, v[i]};
        end
    endfunction

    // Hazard check against registered pending bits only.
    always_comb begin
        w_issue_ready = 1'b1;
        if ((bus.issue_rs_use_i[0] && r_pending[bus.issue_frs1_i]) ||
            (bus.issue_rs_use_i[1] && r_pending[bus.issue_frs2_i]) ||
            (bus.issue_rs_use_i[2] && r_pending[bus.issue_frs3_i]) ||
            (bus.issue_wr_i        && r_pending[bus.issue_frd_i])) begin
            w_issue_ready = 1'b0;
        end else begin
            w_issue_ready = 1'b1;
        end
        w_fire = bus.issue_valid_i && w_issue_ready;
    end

    // Writeback arbiter; requests are rotated so the search always starts at bit 0.
    always_comb begin
        w_req  = {bus.mov_wb_valid_i, bus.fpu_wb_valid_i, bus.lsu_wb_valid_i};
        w_rot  = 3'b000;
        w_pick = 3'b000;
        w_gnt  = 3'b000;
        if (RR_EN) begin
            case (r_ptr)
                PTR_FPU: begin
                    w_rot  = {w_req[0], w_req[2], w_req[1]};
                    w_pick = first_one(w_rot);
                    w_gnt  = {w_pick[1], w_pick[0], w_pick[2]};
                end
                PTR_MOV: begin
                    w_rot  = {w_req[1], w_req[0], w_req[2]};
                    w_pick = first_one(w_rot);
                    w_gnt  = {w_pick[0], w_pick[2], w_pick[1]};
                end
                default: begin
                    w_gnt = first_one(w_req);
                end
            endcase
        end else begin
            w_gnt = first_one(w_req);
        end
        w_any = |w_gnt;
    end

    // Winner payload mux and next round-robin pointer.
    always_comb begin
        w_sel_frd  = 5'd0;
        w_sel_data = '0;
        w_ptr_nxt  = r_ptr;
        case (w_gnt)
            3'b001: begin
                w_sel_frd  = bus.lsu_wb_frd_i;
                w_sel_data = bus.lsu_wb_data_i;
                w_ptr_nxt  = PTR_FPU;
            end
            3'b010: begin
                w_sel_frd  = bus.fpu_wb_frd_i;
                w_sel_data = bus.fpu_wb_data_i;
                w_ptr_nxt  = PTR_MOV;
            end
            3'b100: begin
                w_sel_frd  = bus.mov_wb_frd_i;
                w_sel_data = bus.mov_wb_data_i;
                w_ptr_nxt  = PTR_LSU;
            end
            default: begin
                w_sel_frd  = 5'd0;
                w_sel_data = '0;
                w_ptr_nxt  = r_ptr;
            end
        endcase
    end

    // Scoreboard next state; a bit retiring this cycle no longer counts as pending for error detection.
    always_comb begin
        w_set = 32'd0;
        w_clr = 32'd0;
        if (w_fire && bus.issue_wr_i) begin
            w_set = 32'd1 << bus.issue_frd_i;
        end else begin
            w_set = 32'd0;
        end
        if (r_fregwrite) begin
            w_clr = 32'd1 << r_frd;
        end else begin
            w_clr = 32'd0;
        end
        w_pending_nxt = (r_pending & ~w_clr) | w_set;
        w_err_hit     = w_any && !(r_pending[w_sel_frd] && !w_clr[w_sel_frd]);
    end

    // State registers: scoreboard, write stage, arbiter pointer, sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending   <= 32'd0;
            r_cnt       <= 6'd0;
            r_fregwrite <= 1'b0;
            r_frd       <= 5'd0;
            r_data      <= '0;
            r_ptr       <= PTR_LSU;
            r_wb_err    <= 1'b0;
        end else begin
            r_pending   <= w_pending_nxt;
            r_cnt       <= popcount32(w_pending_nxt);
            r_fregwrite <= w_any;
            r_ptr       <= w_ptr_nxt;
            if (w_any) begin
                r_frd  <= w_sel_frd;
                r_data <= w_sel_data;
            end
            if (w_err_hit) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign bus.issue_ready_o    = w_issue_ready;
    assign bus.lsu_wb_ready_o   = w_gnt[0];
    assign bus.fpu_wb_ready_o   = w_gnt[1];
    assign bus.mov_wb_ready_o   = w_gnt[2];
    assign bus.fregwrite_o      = r_fregwrite;
    assign bus.frd_o            = r_frd;
    assign bus.writeback_data_o = r_data;
    assign bus.pending_cnt_o    = r_cnt;
    assign bus.busy_o           = (r_cnt != 6'd0) || r_fregwrite;
    assign bus.wb_err_o         = r_wb_err;
endmodule

// File: tb/tb_fp_wb_scheduler.sv
// Directed bench: u_rr (round-robin) carries the scoreboard, RR and error scenarios,
// u_fx (fixed priority) carries the starvation scenario; the other one is kept idle.
module tb_fp_wb_scheduler;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en0 = 1'b1;
    logic        en1 = 1'b0;
    logic        iv = 1'b0;
    logic [2:0]  use_m = 3'd0;
    logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rs3 = 5'd0, frd = 5'd0;
    logic        wr = 1'b0;
    logic        lv = 1'b0, fv = 1'b0, mv = 1'b0;
    logic [4:0]  lfrd = 5'd0, ffrd = 5'd0, mfrd = 5'd0;
    logic [31:0] ldat = 32'd0, fdat = 32'd0, mdat = 32'd0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk_i = ~clk_i;

    fp_wb_scheduler_if #(.DATA_W(32)) b0 ();
    fp_wb_scheduler_if #(.DATA_W(32)) b1 ();

    assign b0.issue_valid_i  = en0 & iv;
    assign b0.issue_rs_use_i = use_m;
    assign b0.issue_frs1_i   = rs1;
    assign b0.issue_frs2_i   = rs2;
    assign b0.issue_frs3_i   = rs3;
    assign b0.issue_wr_i     = wr;
    assign b0.issue_frd_i    = frd;
    assign b0.lsu_wb_valid_i = en0 & lv;
    assign b0.fpu_wb_valid_i = en0 & fv;
    assign b0.mov_wb_valid_i = en0 & mv;
    assign b0.lsu_wb_frd_i   = lfrd;
    assign b0.fpu_wb_frd_i   = ffrd;
    assign b0.mov_wb_frd_i   = mfrd;
    assign b0.lsu_wb_data_i  = ldat;
    assign b0.fpu_wb_data_i  = fdat;
    assign b0.mov_wb_data_i  = mdat;

    assign b1.issue_valid_i  = en1 & iv;
    assign b1.issue_rs_use_i = use_m;
    assign b1.issue_frs1_i   = rs1;
    assign b1.issue_frs2_i   = rs2;
    assign b1.issue_frs3_i   = rs3;
    assign b1.issue_wr_i     = wr;
    assign b1.issue_frd_i    = frd;
    assign b1.lsu_wb_valid_i = en1 & lv;
    assign b1.fpu_wb_valid_i = en1 & fv;
    assign b1.mov_wb_valid_i = en1 & mv;
    assign b1.lsu_wb_frd_i   = lfrd;
    assign b1.fpu_wb_frd_i   = ffrd;
    assign b1.mov_wb_frd_i   = mfrd;
    assign b1.lsu_wb_data_i  = ldat;
    assign b1.fpu_wb_data_i  = fdat;
    assign b1.mov_wb_data_i  = mdat;

    fp_wb_scheduler #(.DATA_W(32), .RR_EN(1'b1)) u_rr (.clk_i(clk_i), .rst_ni(rst_ni), .bus(b0));
    fp_wb_scheduler #(.DATA_W(32), .RR_EN(1'b0)) u_fx (.clk_i(clk_i), .rst_ni(rst_ni), .bus(b1));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic at_sample();
        @(negedge clk_i);
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        next_cyc();
        next_cyc();
        rst_ni = 1'b1;
    endtask

    initial begin
        // Reset and idle
        do_reset();
        use_m = 3'b111; rs1 = 5'd5; rs2 = 5'd6; rs3 = 5'd7; wr = 1'b1; frd = 5'd8;
        at_sample();
        check_val("rst_fregwrite", {31'd0, b0.fregwrite_o}, 32'd0);
        check_val("rst_frd", {27'd0, b0.frd_o}, 32'd0);
        check_val("rst_data", b0.writeback_data_o, 32'd0);
        check_val("rst_cnt", {26'd0, b0.pending_cnt_o}, 32'd0);
        check_val("rst_busy", {31'd0, b0.busy_o}, 32'd0);
        check_val("rst_err", {31'd0, b0.wb_err_o}, 32'd0);
        check_val("rst_ready", {31'd0, b0.issue_ready_o}, 32'd1);

        // RAW: write f5, then reader of f5 stalls until the FPU write retires
        next_cyc();
        iv = 1'b1; wr = 1'b1; frd = 5'd5; use_m = 3'b000;
        at_sample();
        check_val("raw_issue_wr_ready", {31'd0, b0.issue_ready_o}, 32'd1);
        next_cyc();
        wr = 1'b0; use_m = 3'b001; rs1 = 5'd5;
        at_sample();
        check_val("raw_stall", {31'd0, b0.issue_ready_o}, 32'd0);
        check_val("raw_cnt1", {26'd0, b0.pending_cnt_o}, 32'd1);
        check_val("raw_busy", {31'd0, b0.busy_o}, 32'd1);
        next_cyc();
        fv = 1'b1; ffrd = 5'd5; fdat = 32'h3F80_0000;
        at_sample();
        check_val("raw_fpu_ready", {31'd0, b0.fpu_wb_ready_o}, 32'd1);
        check_val("raw_still_stall", {31'd0, b0.issue_ready_o}, 32'd0);
        next_cyc();
        fv = 1'b0;
        at_sample();
        check_val("raw_fregwrite", {31'd0, b0.fregwrite_o}, 32'd1);
        check_val("raw_frd_o", {27'd0, b0.frd_o}, 32'd5);
        check_val("raw_data_o", b0.writeback_data_o, 32'h3F80_0000);
        check_val("raw_cnt_during_wr", {26'd0, b0.pending_cnt_o}, 32'd1);
        check_val("raw_stall_during_wr", {31'd0, b0.issue_ready_o}, 32'd0);
        next_cyc();
        at_sample();
        check_val("raw_fregwrite_off", {31'd0, b0.fregwrite_o}, 32'd0);
        check_val("raw_cnt0", {26'd0, b0.pending_cnt_o}, 32'd0);
        check_val("raw_accept", {31'd0, b0.issue_ready_o}, 32'd1);

        // WAW: second write to f7 stalls until the first retires
        next_cyc();
        use_m = 3'b000; wr = 1'b1; frd = 5'd7;
        at_sample();
        check_val("waw_first_ready", {31'd0, b0.issue_ready_o}, 32'd1);
        next_cyc();
        at_sample();
        check_val("waw_stall", {31'd0, b0.issue_ready_o}, 32'd0);
        next_cyc();
        fv = 1'b1; ffrd = 5'd7; fdat = 32'h4000_0000;
        at_sample();
        check_val("waw_stall2", {31'd0, b0.issue_ready_o}, 32'd0);
        next_cyc();
        fv = 1'b0;
        at_sample();
        check_val("waw_frd_o", {27'd0, b0.frd_o}, 32'd7);
        check_val("waw_stall_during_wr", {31'd0, b0.issue_ready_o}, 32'd0);
        next_cyc();
        at_sample();
        check_val("waw_released", {31'd0, b0.issue_ready_o}, 32'd1);
        next_cyc();
        iv = 1'b0;
        at_sample();
        check_val("waw_cnt_reissued", {26'd0, b0.pending_cnt_o}, 32'd1);
        next_cyc();
        fv = 1'b1;
        next_cyc();
        fv = 1'b0;
        next_cyc();
        at_sample();
        check_val("waw_cnt0", {26'd0, b0.pending_cnt_o}, 32'd0);
        check_val("waw_no_err", {31'd0, b0.wb_err_o}, 32'd0);

        // Round-robin from a fresh pointer: LSU, FPU, MOV
        next_cyc();
        do_reset();
        iv = 1'b1; wr = 1'b1; use_m = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            frd = 5'(i);
            next_cyc();
        end
        iv = 1'b0;
        lv = 1'b1; lfrd = 5'd1; ldat = 32'hAAAA_0001;
        fv = 1'b1; ffrd = 5'd2; fdat = 32'hBBBB_0002;
        mv = 1'b1; mfrd = 5'd3; mdat = 32'hCCCC_0003;
        at_sample();
        check_val("rr_cnt3", {26'd0, b0.pending_cnt_o}, 32'd3);
        check_val("rr_gnt0", {29'd0, b0.mov_wb_ready_o, b0.fpu_wb_ready_o, b0.lsu_wb_ready_o}, 32'b001);
        next_cyc();
        lv = 1'b0;
        at_sample();
        check_val("rr_wr0_frd", {27'd0, b0.frd_o}, 32'd1);
        check_val("rr_wr0_data", b0.writeback_data_o, 32'hAAAA_0001);
        check_val("rr_gnt1", {29'd0, b0.mov_wb_ready_o, b0.fpu_wb_ready_o, b0.lsu_wb_ready_o}, 32'b010);
        next_cyc();
        fv = 1'b0;
        at_sample();
        check_val("rr_wr1_frd", {27'd0, b0.frd_o}, 32'd2);
        check_val("rr_gnt2", {29'd0, b0.mov_wb_ready_o, b0.fpu_wb_ready_o, b0.lsu_wb_ready_o}, 32'b100);
        check_val("rr_cnt2", {26'd0, b0.pending_cnt_o}, 32'd2);
        next_cyc();
        mv = 1'b0;
        at_sample();
        check_val("rr_wr2_frd", {27'd0, b0.frd_o}, 32'd3);
        check_val("rr_wr2_data", b0.writeback_data_o, 32'hCCCC_0003);
        check_val("rr_cnt1", {26'd0, b0.pending_cnt_o}, 32'd1);
        next_cyc();
        at_sample();
        check_val("rr_cnt0", {26'd0, b0.pending_cnt_o}, 32'd0);
        check_val("rr_busy0", {31'd0, b0.busy_o}, 32'd0);

        // Fixed priority on u_fx: LSU starves FPU/MOV, then FPU before MOV
        next_cyc();
        en0 = 1'b0; en1 = 1'b1;
        iv = 1'b1; wr = 1'b1; use_m = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            frd = 5'(i);
            next_cyc();
        end
        iv = 1'b0;
        lv = 1'b1; lfrd = 5'd1;
        fv = 1'b1; ffrd = 5'd2;
        mv = 1'b1; mfrd = 5'd3;
        at_sample();
        check_val("fx_cnt4", {26'd0, b1.pending_cnt_o}, 32'd4);
        check_val("fx_gnt0", {29'd0, b1.mov_wb_ready_o, b1.fpu_wb_ready_o, b1.lsu_wb_ready_o}, 32'b001);
        next_cyc();
        lfrd = 5'd4;
        at_sample();
        check_val("fx_gnt1", {29'd0, b1.mov_wb_ready_o, b1.fpu_wb_ready_o, b1.lsu_wb_ready_o}, 32'b001);
        next_cyc();
        lv = 1'b0;
        at_sample();
        check_val("fx_wr1_frd", {27'd0, b1.frd_o}, 32'd4);
        check_val("fx_gnt2", {29'd0, b1.mov_wb_ready_o, b1.fpu_wb_ready_o, b1.lsu_wb_ready_o}, 32'b010);
        next_cyc();
        fv = 1'b0;
        at_sample();
        check_val("fx_wr2_frd", {27'd0, b1.frd_o}, 32'd2);
        check_val("fx_gnt3", {29'd0, b1.mov_wb_ready_o, b1.fpu_wb_ready_o, b1.lsu_wb_ready_o}, 32'b100);
        next_cyc();
        mv = 1'b0;
        at_sample();
        check_val("fx_wr3_frd", {27'd0, b1.frd_o}, 32'd3);
        next_cyc();
        at_sample();
        check_val("fx_cnt0", {26'd0, b1.pending_cnt_o}, 32'd0);
        check_val("fx_no_err", {31'd0, b1.wb_err_o}, 32'd0);

        // Writeback to a non-pending register sets the sticky error
        next_cyc();
        en0 = 1'b1; en1 = 1'b0;
        mv = 1'b1; mfrd = 5'd9; mdat = 32'h1234_5678;
        at_sample();
        check_val("err_mov_ready", {31'd0, b0.mov_wb_ready_o}, 32'd1);
        check_val("err_before", {31'd0, b0.wb_err_o}, 32'd0);
        next_cyc();
        mv = 1'b0;
        at_sample();
        check_val("err_write_frd", {27'd0, b0.frd_o}, 32'd9);
        check_val("err_write_data", b0.writeback_data_o, 32'h1234_5678);
        check_val("err_set", {31'd0, b0.wb_err_o}, 32'd1);
        next_cyc();
        at_sample();
        check_val("err_sticky", {31'd0, b0.wb_err_o}, 32'd1);

        // Asynchronous reset with a grant in flight
        next_cyc();
        iv = 1'b1; wr = 1'b1; frd = 5'd10; use_m = 3'b000;
        next_cyc();
        iv = 1'b0;
        fv = 1'b1; ffrd = 5'd10; fdat = 32'hDEAD_BEEF;
        next_cyc();
        fv = 1'b0;
        check_val("ar_inflight", {31'd0, b0.fregwrite_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("ar_fregwrite", {31'd0, b0.fregwrite_o}, 32'd0);
        check_val("ar_cnt", {26'd0, b0.pending_cnt_o}, 32'd0);
        check_val("ar_err", {31'd0, b0.wb_err_o}, 32'd0);
        check_val("ar_busy", {31'd0, b0.busy_o}, 32'd0);
        check_val("ar_frd", {27'd0, b0.frd_o}, 32'd0);
        next_cyc();
        rst_ni = 1'b1;
        at_sample();
        check_val("ar_ready_after", {31'd0, b0.issue_ready_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
